// File: rtl/cint_sequencer_if.sv
// Memory request port shared by the CINT sequencer (master) and the memory arbiter (slave).
interface cint_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/cint_sequencer.sv
// CINT sequencer: pushes the return PC, fetches the handler vector, then loads PC and SP.
// Every output is a flop whose next value is chosen alongside the next state.
module cint_sequencer #(
    parameter logic [15:0] VEC_BASE = 16'h0000,
    parameter logic [15:0] IOP_BASE = 16'hFF00
) (
    input  logic                    clk,
    input  logic                    not_reset,
    input  logic                    enable_cint,
    input  logic                    PA_Select_IOP_low,
    input  logic [3:0]              cint_vec,
    input  logic [15:0]             pc_in,
    input  logic [15:0]             sp_in,
    cint_sequencer_if.master        mem,
    output logic                    pc_load,
    output logic [15:0]             pc_out,
    output logic                    sp_load,
    output logic [15:0]             sp_out,
    output logic                    not_busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PUSH_HI  = 3'd1;
    localparam logic [2:0] S_PUSH_LO  = 3'd2;
    localparam logic [2:0] S_FETCH_HI = 3'd3;
    localparam logic [2:0] S_FETCH_LO = 3'd4;
    localparam logic [2:0] S_LOAD     = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] sp_q, sp_d;
    logic [3:0]  vec_q, vec_d;
    logic        iop_q, iop_d;
    logic [7:0]  handler_hi_q, handler_hi_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        pc_load_q, pc_load_d;
    logic        sp_load_q, sp_load_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] sp_out_q, sp_out_d;
    logic        not_busy_q, not_busy_d;

    logic [15:0] vec_addr;

    assign vec_addr = (iop_q ? IOP_BASE : VEC_BASE) + {11'd0, vec_q, 1'b0};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        vec_d        = vec_q;
        iop_d        = iop_q;
        handler_hi_d = handler_hi_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        pc_load_d    = 1'b0;
        sp_load_d    = 1'b0;
        pc_out_d     = pc_out_q;
        sp_out_d     = sp_out_q;
        not_busy_d   = not_busy_q;

        // Each memory state stays put until acked, then sets up the next request.
        case (state_q)
            S_IDLE: begin
                if (enable_cint) begin
                    pc_d        = pc_in;
                    sp_d        = sp_in;
                    vec_d       = cint_vec;
                    iop_d       = PA_Select_IOP_low;
                    state_d     = S_PUSH_HI;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = sp_in - 16'd1;
                    mem_wdata_d = pc_in[15:8];
                    not_busy_d  = 1'b0;
                end
            end
            S_PUSH_HI: begin
                if (mem.mem_ack) begin
                    state_d     = S_PUSH_LO;
                    mem_addr_d  = sp_q - 16'd2;
                    mem_wdata_d = pc_q[7:0];
                end
            end
            S_PUSH_LO: begin
                if (mem.mem_ack) begin
                    state_d    = S_FETCH_HI;
                    mem_we_d   = 1'b0;
                    mem_addr_d = vec_addr;
                end
            end
            S_FETCH_HI: begin
                if (mem.mem_ack) begin
                    state_d      = S_FETCH_LO;
                    handler_hi_d = mem.mem_rdata;
                    mem_addr_d   = vec_addr + 16'd1;
                end
            end
            S_FETCH_LO: begin
                // The low handler byte goes straight into pc_out so LOAD needs no extra cycle.
                if (mem.mem_ack) begin
                    state_d   = S_LOAD;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    pc_load_d = 1'b1;
                    sp_load_d = 1'b1;
                    pc_out_d  = {handler_hi_q, mem.mem_rdata};
                    sp_out_d  = sp_q - 16'd2;
                end
            end
            S_LOAD: begin
                state_d    = S_IDLE;
                not_busy_d = 1'b1;
            end
            default: begin
                state_d    = S_IDLE;
                mem_req_d  = 1'b0;
                mem_we_d   = 1'b0;
                not_busy_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!not_reset) begin
            state_q      <= S_IDLE;
            pc_q         <= 16'd0;
            sp_q         <= 16'd0;
            vec_q        <= 4'd0;
            iop_q        <= 1'b0;
            handler_hi_q <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 8'd0;
            pc_load_q    <= 1'b0;
            sp_load_q    <= 1'b0;
            pc_out_q     <= 16'd0;
            sp_out_q     <= 16'd0;
            not_busy_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            vec_q        <= vec_d;
            iop_q        <= iop_d;
            handler_hi_q <= handler_hi_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            pc_load_q    <= pc_load_d;
            sp_load_q    <= sp_load_d;
            pc_out_q     <= pc_out_d;
            sp_out_q     <= sp_out_d;
            not_busy_q   <= not_busy_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign pc_load       = pc_load_q;
    assign sp_load       = sp_load_q;
    assign pc_out        = pc_out_q;
    assign sp_out        = sp_out_q;
    assign not_busy      = not_busy_q;

endmodule

// File: tb/tb_cint_sequencer.sv
// Self-checking bench for cint_sequencer: vector table, memory responder with a transaction
// scoreboard, a load-result scoreboard, and hand-written corner-case sequences.
module tb_cint_sequencer;

    logic        clk;
    logic        not_reset;
    logic        enable_cint;
    logic        PA_Select_IOP_low;
    logic [3:0]  cint_vec;
    logic [15:0] pc_in;
    logic [15:0] sp_in;
    logic        pc_load;
    logic [15:0] pc_out;
    logic        sp_load;
    logic [15:0] sp_out;
    logic        not_busy;

    cint_sequencer_if mem_bus ();

    cint_sequencer dut (
        .clk               (clk),
        .not_reset         (not_reset),
        .enable_cint       (enable_cint),
        .PA_Select_IOP_low (PA_Select_IOP_low),
        .cint_vec          (cint_vec),
        .pc_in             (pc_in),
        .sp_in             (sp_in),
        .mem               (mem_bus),
        .pc_load           (pc_load),
        .pc_out            (pc_out),
        .sp_load           (sp_load),
        .sp_out            (sp_out),
        .not_busy          (not_busy)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] sp;
        logic [3:0]  vec;
        logic        iop;
        logic [7:0]  rd_hi;
        logic [7:0]  rd_lo;
        int          ack_wait;
        logic [15:0] wa_hi;
        logic [7:0]  wd_hi;
        logic [15:0] wa_lo;
        logic [7:0]  wd_lo;
        logic [15:0] ra_hi;
        logic [15:0] ra_lo;
        logic [15:0] exp_pc;
        logic [15:0] exp_sp;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } txn_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] sp;
    } res_t;

    txn_t mem_q[$];
    res_t res_q[$];
    vec_t vecs[5];

    int checks_total  = 0;
    int checks_passed = 0;
    int ack_wait      = 0;
    int wait_cnt      = 0;
    int busy_cnt      = 0;
    int load_cnt      = 0;
    logic spurious_ack = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Memory responder: checks each request against the head of the scoreboard on every cycle
    // it is held, acks after ack_wait wait cycles and returns the scripted read byte.
    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req) begin
                if (mem_q.size() == 0) begin
                    checkOutput("unexpected_req", 32'd1, 32'd0);
                    mem_bus.mem_ack = 1'b1;
                end else begin
                    checkOutput("mem_we", {31'd0, mem_bus.mem_we}, {31'd0, mem_q[0].we});
                    checkOutput("mem_addr", {16'd0, mem_bus.mem_addr}, {16'd0, mem_q[0].addr});
                    if (mem_q[0].we)
                        checkOutput("mem_wdata", {24'd0, mem_bus.mem_wdata}, {24'd0, mem_q[0].wdata});
                    if (wait_cnt < ack_wait) begin
                        mem_bus.mem_ack = 1'b0;
                        wait_cnt++;
                    end else begin
                        mem_bus.mem_ack   = 1'b1;
                        mem_bus.mem_rdata = mem_q[0].rdata;
                        void'(mem_q.pop_front());
                        wait_cnt = 0;
                    end
                end
            end else begin
                wait_cnt        = 0;
                mem_bus.mem_ack = spurious_ack;
            end
        end
    end

    // Load monitor: every load strobe must carry both strobes and the scoreboarded PC/SP.
    initial begin
        forever begin
            @(negedge clk);
            if (not_reset && !not_busy) busy_cnt++;
            if (pc_load || sp_load) begin
                load_cnt++;
                checkOutput("pc_load", {31'd0, pc_load}, 32'd1);
                checkOutput("sp_load", {31'd0, sp_load}, 32'd1);
                if (res_q.size() == 0) begin
                    checkOutput("unexpected_load", 32'd1, 32'd0);
                end else begin
                    checkOutput("pc_out", {16'd0, pc_out}, {16'd0, res_q[0].pc});
                    checkOutput("sp_out", {16'd0, sp_out}, {16'd0, res_q[0].sp});
                    void'(res_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    // Called at a falling edge; the strobe is sampled at the next rising edge.
    task automatic applyStimulus(input vec_t v);
        pc_in             = v.pc;
        sp_in             = v.sp;
        cint_vec          = v.vec;
        PA_Select_IOP_low = v.iop;
        ack_wait          = v.ack_wait;
        busy_cnt          = 0;
        mem_q.push_back('{1'b1, v.wa_hi, v.wd_hi, 8'h00});
        mem_q.push_back('{1'b1, v.wa_lo, v.wd_lo, 8'h00});
        mem_q.push_back('{1'b0, v.ra_hi, 8'h00, v.rd_hi});
        mem_q.push_back('{1'b0, v.ra_lo, 8'h00, v.rd_lo});
        res_q.push_back('{v.exp_pc, v.exp_sp});
        enable_cint = 1'b1;
        @(posedge clk);
        #1 enable_cint = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!not_busy && n < 200);
        if (n >= 200) checkOutput({name, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic runVector(input string name, input vec_t v);
        int loads_before;
        loads_before = load_cnt;
        applyStimulus(v);
        waitIdle(name);
        checkOutput({name, "_busy_cycles"}, busy_cnt, v.exp_busy);
        checkOutput({name, "_load_count"}, load_cnt - loads_before, 32'd1);
        checkOutput({name, "_mem_q_empty"}, mem_q.size(), 32'd0);
        checkOutput({name, "_req_idle"}, {31'd0, mem_bus.mem_req}, 32'd0);
    endtask

    initial begin
        int loads_before;
        //            pc       sp      vec  iop rd_hi  rd_lo wait wa_hi    wd_hi  wa_lo    wd_lo  ra_hi    ra_lo    exp_pc   exp_sp  busy
        vecs[0] = '{16'h1234, 16'h8000, 4'h3, 1'b0, 8'hAB, 8'hCD, 0, 16'h7FFF, 8'h12, 16'h7FFE, 8'h34, 16'h0006, 16'h0007, 16'hABCD, 16'h7FFE, 5};
        vecs[1] = '{16'h1234, 16'h8000, 4'hF, 1'b1, 8'hAB, 8'hCD, 0, 16'h7FFF, 8'h12, 16'h7FFE, 8'h34, 16'hFF1E, 16'hFF1F, 16'hABCD, 16'h7FFE, 5};
        vecs[2] = '{16'h1234, 16'h8000, 4'h3, 1'b0, 8'hAB, 8'hCD, 3, 16'h7FFF, 8'h12, 16'h7FFE, 8'h34, 16'h0006, 16'h0007, 16'hABCD, 16'h7FFE, 17};
        vecs[3] = '{16'h5A6B, 16'h0000, 4'h0, 1'b0, 8'h12, 8'h34, 0, 16'hFFFF, 8'h5A, 16'hFFFE, 8'h6B, 16'h0000, 16'h0001, 16'h1234, 16'hFFFE, 5};
        vecs[4] = '{16'hFEDC, 16'h1234, 4'h7, 1'b1, 8'h5A, 8'hA5, 1, 16'h1233, 8'hFE, 16'h1232, 8'hDC, 16'hFF0E, 16'hFF0F, 16'h5AA5, 16'h1232, 9};

        // Reset held with the strobe asserted: reset must win.
        not_reset         = 1'b0;
        enable_cint       = 1'b1;
        PA_Select_IOP_low = 1'b0;
        cint_vec          = 4'h1;
        pc_in             = 16'hAAAA;
        sp_in             = 16'h5555;
        repeat (3) @(negedge clk);
        checkOutput("rst_not_busy", {31'd0, not_busy}, 32'd1);
        checkOutput("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
        checkOutput("rst_mem_addr", {16'd0, mem_bus.mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", {24'd0, mem_bus.mem_wdata}, 32'd0);
        checkOutput("rst_pc_out", {16'd0, pc_out}, 32'd0);
        checkOutput("rst_sp_out", {16'd0, sp_out}, 32'd0);
        checkOutput("rst_loads", {30'd0, pc_load, sp_load}, 32'd0);
        enable_cint = 1'b0;
        not_reset   = 1'b1;
        @(negedge clk);

        // Table vectors run back to back: each new strobe goes in the first idle cycle.
        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d", i);
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Strobe pulsed during PUSH_LO must be ignored and must not queue a second sequence.
        loads_before = load_cnt;
        applyStimulus(vecs[0]);
        @(negedge clk);
        @(negedge clk);
        enable_cint = 1'b1;
        pc_in       = 16'hFFFF;
        sp_in       = 16'h1111;
        cint_vec    = 4'h9;
        @(negedge clk);
        enable_cint = 1'b0;
        waitIdle("ignored_strobe");
        checkOutput("ignored_busy_cycles", busy_cnt, 32'd5);
        repeat (4) @(negedge clk);
        checkOutput("ignored_still_idle", {31'd0, not_busy}, 32'd1);
        checkOutput("ignored_load_count", load_cnt - loads_before, 32'd1);
        checkOutput("ignored_mem_q_empty", mem_q.size(), 32'd0);

        // Spurious ack in IDLE: nothing moves and the last address is held.
        spurious_ack = 1'b1;
        repeat (3) @(negedge clk);
        spurious_ack = 1'b0;
        checkOutput("spurious_not_busy", {31'd0, not_busy}, 32'd1);
        checkOutput("spurious_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        checkOutput("spurious_addr_held", {16'd0, mem_bus.mem_addr}, 32'h0007);
        checkOutput("spurious_pc_out_held", {16'd0, pc_out}, 32'hABCD);
        @(negedge clk);

        // Reset during FETCH_HI aborts the sequence without any load strobe.
        loads_before = load_cnt;
        applyStimulus(vecs[1]);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        not_reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_not_busy", {31'd0, not_busy}, 32'd1);
        checkOutput("abort_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        checkOutput("abort_mem_addr", {16'd0, mem_bus.mem_addr}, 32'd0);
        checkOutput("abort_pc_out", {16'd0, pc_out}, 32'd0);
        checkOutput("abort_sp_out", {16'd0, sp_out}, 32'd0);
        checkOutput("abort_pending_txns", mem_q.size(), 32'd1);
        mem_q.delete();
        res_q.delete();
        not_reset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abort_no_load", load_cnt - loads_before, 32'd0);
        checkOutput("abort_idle", {31'd0, not_busy}, 32'd1);

        // A fresh sequence after the abort still works.
        runVector("post_abort", vecs[3]);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
